lvds_tx: RTL and testbench



---
 rtl/lvds_tx_pkg.sv | 30 +++
 rtl/lvds_tx_shifter.sv | 30 +++
 rtl/lvds_tx.sv | 118 +++++++++++
 tb/tb_lvds_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_tx_pkg.sv
// Shared constants, state encoding and sync-forcing helper for the LVDS I/Q transmitter.
// Pure definitions: no latency, no flow control.
package lvds_tx_pkg;

  localparam int FRAME_W        = 32;
  localparam int BITS_PER_CYCLE = 2;

  localparam logic [3:0] PHASE_PULL = 4'd14;
  localparam logic [3:0] PHASE_LAST = 4'd15;

  localparam logic [1:0] I_SYNC = 2'b10;
  localparam logic [1:0] Q_SYNC = 2'b01;

  localparam logic [FRAME_W-1:0] ZERO_FRAME = 32'h8000_4000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Sync pairs are overwritten; control bits [16] and [0] pass untouched.
  function automatic logic [FRAME_W-1:0] force_sync(input logic [FRAME_W-1:0] i_word);
    logic [FRAME_W-1:0] w_word;
    w_word        = i_word;
    w_word[31:30] = I_SYNC;
    w_word[15:14] = Q_SYNC;
    return w_word;
  endfunction

endpackage

// File: rtl/lvds_tx_shifter.sv
// 32-bit load/shift register; emits the top bit pair of the held word, shifts left by 2 each cycle.
// Loaded word is visible on o_bits the cycle after the load; no backpressure.
module lvds_tx_shifter
  import lvds_tx_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_load,
  input  logic                      i_clear,
  input  logic [FRAME_W-1:0]        i_load_dat,
  output logic [BITS_PER_CYCLE-1:0] o_bits
);

  logic [FRAME_W-1:0] r_sr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr <= '0;
    end else if (i_clear) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_load_dat;
    end else begin
      r_sr <= {r_sr[FRAME_W-BITS_PER_CYCLE-1:0], {BITS_PER_CYCLE{1'b0}}};
    end
  end

  assign o_bits = r_sr[FRAME_W-1 -: BITS_PER_CYCLE];

endmodule

// File: rtl/lvds_tx.sv
// LVDS I/Q transmitter: prefetches a FIFO word at phase 14, serialises 16-cycle frames MSB-first
// with no inter-frame bubble; FIFO underflow inserts a counted zero frame instead of stalling.
module lvds_tx
  import lvds_tx_pkg::*;
#(
  parameter int                 UNDERFLOW_W = 16,
  parameter logic [FRAME_W-1:0] ZERO_FRAME  = lvds_tx_pkg::ZERO_FRAME
) (
  input  logic                   i_ddr_clk,
  input  logic                   i_rst,
  input  logic                   i_tx_enable,
  input  logic                   i_fifo_empty,
  output logic                   o_fifo_pull,
  input  logic [FRAME_W-1:0]     i_fifo_data,
  output logic [1:0]             o_ddr_data,
  output logic                   o_busy,
  output logic [UNDERFLOW_W-1:0] o_underflow_cnt
);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [3:0]             r_phase;
  logic [3:0]             w_phase_nxt;
  logic                   r_next_valid;
  logic [UNDERFLOW_W-1:0] r_uf_cnt;
  logic                   w_load;
  logic                   w_clear;
  logic                   w_cnt_inc;
  logic                   w_pull;
  logic [FRAME_W-1:0]     w_load_dat;
  logic [1:0]             w_bits;

  always_ff @(posedge i_ddr_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_cnt_inc   = 1'b0;
    w_pull      = 1'b0;
    w_load_dat  = force_sync(ZERO_FRAME);
    case (r_state)
      IDLE: begin
        w_phase_nxt = '0;
        if (i_tx_enable) begin
          w_state_nxt = RUN;
          w_load      = 1'b1;
        end
      end
      RUN: begin
        w_phase_nxt = r_phase + 4'd1;
        if (r_phase == PHASE_PULL && i_tx_enable && !i_fifo_empty) begin
          w_pull = 1'b1;
        end
        if (r_phase == PHASE_LAST) begin
          if (i_tx_enable) begin
            w_load = 1'b1;
            // Read data is valid during phase 15, so it goes straight into the shifter.
            if (r_next_valid) begin
              w_load_dat = force_sync(i_fifo_data);
            end else begin
              w_cnt_inc = 1'b1;
            end
          end else begin
            w_state_nxt = IDLE;
            w_clear     = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_phase_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_ddr_clk or posedge i_rst) begin
    if (i_rst) begin
      r_next_valid <= 1'b0;
    end else if (r_state == RUN && r_phase == PHASE_PULL) begin
      r_next_valid <= w_pull;
    end else if (r_phase == PHASE_LAST || r_state == IDLE) begin
      r_next_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_ddr_clk or posedge i_rst) begin
    if (i_rst) begin
      r_uf_cnt <= '0;
    end else if (w_cnt_inc && (r_uf_cnt != {UNDERFLOW_W{1'b1}})) begin
      r_uf_cnt <= r_uf_cnt + {{(UNDERFLOW_W-1){1'b0}}, 1'b1};
    end
  end

  lvds_tx_shifter u_shifter (
    .i_clk      (i_ddr_clk),
    .i_rst      (i_rst),
    .i_load     (w_load),
    .i_clear    (w_clear),
    .i_load_dat (w_load_dat),
    .o_bits     (w_bits)
  );

  assign o_busy          = (r_state == RUN);
  assign o_ddr_data      = o_busy ? w_bits : 2'b00;
  assign o_fifo_pull     = w_pull;
  assign o_underflow_cnt = r_uf_cnt;

endmodule

// File: tb/tb_lvds_tx.sv
// Scoreboard bench for lvds_tx: stimulus queues expected bit pairs, a negedge monitor compares them.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_lvds_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_enable;
  logic        force_empty;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_pull;
  logic [1:0]  ddr_data;
  logic        busy;
  logic [15:0] uf_cnt;
  logic        d2_pull;
  logic [1:0]  d2_ddr_data;
  logic        d2_busy;
  logic [1:0]  d2_uf_cnt;

  logic [31:0] fifo_mem [0:7];
  logic [3:0]  wr_idx;
  logic [3:0]  rd_idx;

  logic [1:0]  exp_q [$];
  logic [3:0]  mon_phase;
  int          pull_cnt;
  int          checks;
  int          failures;

  always #5 clk = ~clk;

  lvds_tx #(.UNDERFLOW_W(16)) dut (
    .i_ddr_clk       (clk),
    .i_rst           (rst),
    .i_tx_enable     (tx_enable),
    .i_fifo_empty    (fifo_empty),
    .o_fifo_pull     (fifo_pull),
    .i_fifo_data     (fifo_data),
    .o_ddr_data      (ddr_data),
    .o_busy          (busy),
    .o_underflow_cnt (uf_cnt)
  );

  lvds_tx #(.UNDERFLOW_W(2)) dut2 (
    .i_ddr_clk       (clk),
    .i_rst           (rst),
    .i_tx_enable     (tx_enable),
    .i_fifo_empty    (fifo_empty),
    .o_fifo_pull     (d2_pull),
    .i_fifo_data     (fifo_data),
    .o_ddr_data      (d2_ddr_data),
    .o_busy          (d2_busy),
    .o_underflow_cnt (d2_uf_cnt)
  );

  // FIFO model: read data appears on the edge that samples the pull strobe.
  assign fifo_empty = force_empty || (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (fifo_pull) begin
      fifo_data <= fifo_mem[rd_idx[2:0]];
      rd_idx    <= rd_idx + 4'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_pairs(input logic [31:0] word, input int n);
    logic [31:0] t;
    t = word;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(t[31:30]);
      t = {t[29:0], 2'b00};
    end
  endtask

  task automatic fifo_push(input logic [31:0] word);
    fifo_mem[wr_idx[2:0]] = word;
    wr_idx = wr_idx + 4'd1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
    #1;
  endtask

  // Monitor: one expected pair per busy cycle; pulls only at frame phase 14.
  always @(negedge clk) begin
    if (busy && !rst) begin
      if (exp_q.size() == 0) begin
        check("exp_underrun", {30'd0, ddr_data}, 32'hFFFF_FFFF);
      end else begin
        check("ddr_data", {30'd0, ddr_data}, {30'd0, exp_q.pop_front()});
      end
      if (fifo_pull) begin
        pull_cnt++;
        check("pull_phase", {28'd0, mon_phase}, 32'd14);
      end
      mon_phase = mon_phase + 4'd1;
    end else begin
      mon_phase = 4'd0;
      check("idle_data", {30'd0, ddr_data}, 32'd0);
      check("idle_pull", {31'd0, fifo_pull}, 32'd0);
    end
  end

  initial begin
    checks      = 0;
    failures    = 0;
    pull_cnt    = 0;
    mon_phase   = 4'd0;
    wr_idx      = 4'd0;
    rd_idx      = 4'd0;
    fifo_data   = 32'd0;
    rst         = 1'b1;
    tx_enable   = 1'b0;
    force_empty = 1'b0;
    #12;
    check("rst_data", {30'd0, ddr_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pull", {31'd0, fifo_pull}, 32'd0);
    check("rst_cnt", {16'd0, uf_cnt}, 32'd0);
    cycles(2);
    rst = 1'b0;
    cycles(2);

    // Priming zero frame, then one FIFO word with syncs forced.
    fifo_push(32'h3FFF_BFFE);
    push_pairs(32'h8000_4000, 16);
    push_pairs(32'hBFFF_7FFE, 16);
    pull_cnt  = 0;
    tx_enable = 1'b1;
    cycles(21);
    tx_enable = 1'b0;
    wait_idle();
    check("t1_cnt", {16'd0, uf_cnt}, 32'd0);
    check("t1_pulls", pull_cnt, 32'd1);
    check("t1_drained", {31'd0, exp_q.size() == 0}, 32'd1);

    // Four back-to-back frames, disabled at phase 5 of the last one.
    fifo_push(32'h1234_5678);
    fifo_push(32'hFFFF_FFFF);
    fifo_push(32'h0001_0001);
    fifo_push(32'hA5A5_5A5A);
    push_pairs(32'h8000_4000, 16);
    push_pairs(32'h9234_5678, 16);
    push_pairs(32'hBFFF_7FFF, 16);
    push_pairs(32'h8001_4001, 16);
    push_pairs(32'hA5A5_5A5A, 16);
    pull_cnt  = 0;
    tx_enable = 1'b1;
    cycles(70);
    tx_enable = 1'b0;
    check("t2_busy_after_disable", {31'd0, busy}, 32'd1);
    wait_idle();
    check("t2_busy", {31'd0, busy}, 32'd0);
    check("t2_data", {30'd0, ddr_data}, 32'd0);
    check("t2_pulls", pull_cnt, 32'd4);
    check("t2_cnt", {16'd0, uf_cnt}, 32'd0);
    check("t2_drained", {31'd0, exp_q.size() == 0}, 32'd1);

    // Three empty slots after the priming frame.
    force_empty = 1'b1;
    for (int i = 0; i < 4; i++) push_pairs(32'h8000_4000, 16);
    pull_cnt  = 0;
    tx_enable = 1'b1;
    cycles(54);
    tx_enable = 1'b0;
    wait_idle();
    check("t3_cnt", {16'd0, uf_cnt}, 32'd3);
    check("t3_cnt_w2", {30'd0, d2_uf_cnt}, 32'd3);
    check("t3_pulls", pull_cnt, 32'd0);

    // Three more: wide counter keeps counting, narrow one holds at all-ones.
    for (int i = 0; i < 4; i++) push_pairs(32'h8000_4000, 16);
    tx_enable = 1'b1;
    cycles(54);
    tx_enable = 1'b0;
    wait_idle();
    check("t4_cnt", {16'd0, uf_cnt}, 32'd6);
    check("t4_cnt_w2_sat", {30'd0, d2_uf_cnt}, 32'd3);
    check("t4_drained", {31'd0, exp_q.size() == 0}, 32'd1);

    // Reset at phase 9 of the priming frame abandons it immediately.
    push_pairs(32'h8000_4000, 9);
    tx_enable = 1'b1;
    cycles(10);
    check("t5_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_data", {30'd0, ddr_data}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    check("t5_rst_pull", {31'd0, fifo_pull}, 32'd0);
    tx_enable   = 1'b0;
    force_empty = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(2);
    check("t5_cnt", {16'd0, uf_cnt}, 32'd0);
    check("t5_cnt_w2", {30'd0, d2_uf_cnt}, 32'd0);
    check("t5_drained", {31'd0, exp_q.size() == 0}, 32'd1);
    check("fifo_drained", {28'd0, rd_idx}, {28'd0, wr_idx});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
